// File: rtl/wb_host_driver.sv
// Wishbone classic single-transfer initiator: one bus cycle per val/rdy command,
// returning a val/rdy response, with a programmable ack timeout.
module wb_host_driver #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_val,
    output logic        cmd_rdy,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_val,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 4;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [DW-1:0]    adr_q, adr_d;
    logic [DW-1:0]    dat_q, dat_d;
    logic             rsp_val_q, rsp_val_d;
    logic [DW-1:0]    rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;

    // State and output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cmd_rdy_q <= 1'b1;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_val_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_rdy_q <= cmd_rdy_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_val_q <= rsp_val_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_rdy_d = cmd_rdy_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_val_d = rsp_val_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_val) begin
                    state_d   = ST_BUS;
                    cnt_d     = '0;
                    cmd_rdy_d = 1'b0;
                    cyc_d     = 1'b1;
                    we_d      = cmd_we;
                    sel_d     = cmd_sel;
                    adr_d     = cmd_adr;
                    dat_d     = cmd_dat;
                end
            end
            ST_BUS: begin
                // Ack takes priority over a timeout expiring in the same cycle
                if (wbm_ack_i) begin
                    state_d   = ST_RESP;
                    cyc_d     = 1'b0;
                    rsp_val_d = 1'b1;
                    rsp_dat_d = we_q ? '0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d   = ST_RESP;
                    cyc_d     = 1'b0;
                    rsp_val_d = 1'b1;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_rdy) begin
                    state_d   = ST_IDLE;
                    rsp_val_d = 1'b0;
                    cmd_rdy_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cmd_rdy_d = 1'b1;
                cyc_d     = 1'b0;
                rsp_val_d = 1'b0;
            end
        endcase
    end

    assign cmd_rdy   = cmd_rdy_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_val   = rsp_val_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_host_driver.sv
// Self-checking bench for wb_host_driver: scoreboarded commands against a
// scripted Wishbone slave with per-command ack delay.
module tb_wb_host_driver;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_val, cmd_rdy, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_val, rsp_rdy, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    rsp_t        sb_q[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    wb_host_driver #(.TIMEOUT(TO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_val   (cmd_val),
        .cmd_rdy   (cmd_rdy),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_val   (rsp_val),
        .rsp_rdy   (rsp_rdy),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one command; the slave acks in strobe cycle ack_cyc (0 = never).
    // The expected response comes from a small model and is queued at drive time.
    task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int ack_cyc, input logic [31:0] rdata,
                          input int hold, output int stb_cnt, output bit stable,
                          output bit got_rsp, output rsp_t obs, output rsp_t exp,
                          output int lat, output bit bp_ok);
        rsp_t m;
        stb_cnt = 0; stable = 1'b1; got_rsp = 1'b0; lat = 0; bp_ok = 1'b1;
        obs = '0; exp = '0;
        m.err = (ack_cyc == 0) || (ack_cyc > int'(TO));
        m.dat = (m.err || we) ? 32'h0 : rdata;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        rsp_rdy = (hold == 0);
        cmd_val = 1'b1;
        sb_q.push_back(m);
        for (int i = 0; i < 20 && !cmd_rdy; i++) tick();
        tick();
        cmd_val = 1'b0;
        cmd_adr = 32'h5555_5555; cmd_dat = 32'hAAAA_AAAA; cmd_sel = 4'h0; cmd_we = ~we;
        for (int i = 0; i < 40; i++) begin
            lat++;
            if (rsp_val) begin
                got_rsp = 1'b1;
                break;
            end
            if (wbm_cyc_o) begin
                stb_cnt++;
                if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr ||
                    wbm_sel_o !== sel || (we && wbm_dat_o !== dat))
                    stable = 1'b0;
            end else if (wbm_stb_o !== 1'b0) begin
                stable = 1'b0;
            end
            wbm_ack_i = (ack_cyc != 0) && (stb_cnt == ack_cyc) && wbm_cyc_o;
            wbm_dat_i = wbm_ack_i ? rdata : 32'hDEAD_BEEF;
            tick();
        end
        wbm_ack_i = 1'b0;
        exp = sb_q.pop_front();
        if (got_rsp) begin
            obs.dat = rsp_dat;
            obs.err = rsp_err;
            for (int i = 0; i < hold; i++) begin
                cmd_val = 1'b1;
                tick();
                if (rsp_val !== 1'b1 || rsp_dat !== obs.dat || rsp_err !== obs.err ||
                    cmd_rdy !== 1'b0 || wbm_cyc_o !== 1'b0)
                    bp_ok = 1'b0;
            end
            cmd_val = 1'b0;
            rsp_rdy = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_total++;
        if (cmd_rdy !== 1'b1) $display("FAIL reset_cmd_rdy got %b want 1", cmd_rdy);
        else n_pass++;
        n_total++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_val, rsp_err} !== 4'b0000)
            $display("FAIL reset_ctrl got %b want 0000", {wbm_cyc_o, wbm_stb_o, rsp_val, rsp_err});
        else n_pass++;
        n_total++;
        if (rsp_dat !== 32'h0) $display("FAIL reset_rsp_dat got %h want 0", rsp_dat);
        else n_pass++;
    endtask

    task automatic test_write();
        int st; bit sb, gr, bp; rsp_t o, e; int lat;
        do_cmd(1'b1, 32'h3000_0000, 32'h000F_0005, 4'hF, 2, 32'h0, 0, st, sb, gr, o, e, lat, bp);
        n_total++;
        if (!gr || o !== e) $display("FAIL write_rsp got %h/%b want %h/%b", o.dat, o.err, e.dat, e.err);
        else n_pass++;
        n_total++;
        if (st != 2 || !sb) $display("FAIL write_bus stb_cycles %0d stable %0d want 2/1", st, sb);
        else n_pass++;
        n_total++;
        if (lat != 4 || cmd_rdy !== 1'b1) $display("FAIL write_latency got %0d rdy %b want 4/1", lat, cmd_rdy);
        else n_pass++;
    endtask

    task automatic test_read_stall();
        int st; bit sb, gr, bp; rsp_t o, e; int lat;
        do_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF, 7, 32'h0000_0005, 0, st, sb, gr, o, e, lat, bp);
        n_total++;
        if (!gr || o !== e) $display("FAIL read_rsp got %h/%b want %h/%b", o.dat, o.err, e.dat, e.err);
        else n_pass++;
        n_total++;
        if (st != 7 || !sb) $display("FAIL read_stall stb_cycles %0d stable %0d want 7/1", st, sb);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int st; bit sb, gr, bp; rsp_t o, e; int lat;
        do_cmd(1'b0, 32'h3000_0008, 32'h0, 4'h3, 0, 32'h1234_5678, 0, st, sb, gr, o, e, lat, bp);
        n_total++;
        if (!gr || o !== e) $display("FAIL timeout_rsp got %h/%b want %h/%b", o.dat, o.err, e.dat, e.err);
        else n_pass++;
        n_total++;
        if (st != int'(TO) || !sb) $display("FAIL timeout_stb_cycles got %0d want %0d", st, TO);
        else n_pass++;
        do_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 0, st, sb, gr, o, e, lat, bp);
        n_total++;
        if (!gr || o !== e || st != 1) $display("FAIL after_timeout got %h/%b st %0d want %h/%b st 1", o.dat, o.err, st, e.dat, e.err);
        else n_pass++;
    endtask

    task automatic test_ack_at_expiry();
        int st; bit sb, gr, bp; rsp_t o, e; int lat;
        do_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, int'(TO), 32'hA5A5_A5A5, 0, st, sb, gr, o, e, lat, bp);
        n_total++;
        if (!gr || o !== e) $display("FAIL ack_expiry_rsp got %h/%b want %h/%b", o.dat, o.err, e.dat, e.err);
        else n_pass++;
        n_total++;
        if (st != int'(TO)) $display("FAIL ack_expiry_stb_cycles got %0d want %0d", st, TO);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int st; bit sb, gr, bp; rsp_t o, e; int lat;
        do_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF, 3, 32'hCAFE_0042, 5, st, sb, gr, o, e, lat, bp);
        n_total++;
        if (!gr || o !== e) $display("FAIL bp_rsp got %h/%b want %h/%b", o.dat, o.err, e.dat, e.err);
        else n_pass++;
        n_total++;
        if (!bp) $display("FAIL bp_hold stable %0d want 1", bp);
        else n_pass++;
        n_total++;
        if (cmd_rdy !== 1'b1 || rsp_val !== 1'b0) $display("FAIL bp_release rdy %b val %b want 1/0", cmd_rdy, rsp_val);
        else n_pass++;
    endtask

    task automatic test_reset_mid_bus();
        bit quiet = 1'b1;
        cmd_we = 1'b1; cmd_adr = 32'h3000_0020; cmd_dat = 32'h1111_2222; cmd_sel = 4'hF;
        cmd_val = 1'b1;
        for (int i = 0; i < 20 && !cmd_rdy; i++) tick();
        tick();
        cmd_val = 1'b0;
        tick(); tick();
        n_total++;
        if (wbm_cyc_o !== 1'b1) $display("FAIL mid_bus_cyc got %b want 1", wbm_cyc_o);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_val, cmd_rdy} !== 4'b0001)
            $display("FAIL mid_reset got %b want 0001", {wbm_cyc_o, wbm_stb_o, rsp_val, cmd_rdy});
        else n_pass++;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hFEED_FACE;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_val !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_rdy !== 1'b1) quiet = 1'b0;
        end
        wbm_ack_i = 1'b0;
        n_total++;
        if (!quiet) $display("FAIL stray_ack quiet %0d want 1", quiet);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; cmd_val = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_rdy = 1'b1; wbm_dat_i = '0; wbm_ack_i = 1'b0;
        test_reset();
        test_write();
        test_read_stall();
        test_timeout();
        test_ack_at_expiry();
        test_backpressure();
        test_reset_mid_bus();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
